// File: rtl/vcache_dma_channel_mux.sv
// ============================================================================
// Module   : vcache_dma_channel_mux
// Brief    : Funnels vcache DMA ports onto DRAM channels with per-channel
//            round-robin packet arbitration, write-data locking and an in-order
//            read-tag FIFO. Optional macro VCACHE_DMA_CHANNEL_MUX_PERF_EN adds
//            per-channel saturating stall counters (stall_count_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vcache_dma_channel_mux #(
    parameter int num_vcaches_p                = 16,
    parameter int num_channels_p               = 4,
    parameter int map_mode_p                   = 0,
    parameter int vcache_addr_width_p          = 28,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_word_width_p          = 32,
    parameter int vcache_dma_data_width_p      = 32,
    parameter int max_out_reads_p              = 4,
    localparam int pkt_width_lp                = vcache_addr_width_p + 1
) (
    input  logic                                                    clk_i,
    input  logic                                                    reset_n_i,
    input  logic [num_vcaches_p-1:0][pkt_width_lp-1:0]              dma_pkt_i,
    input  logic [num_vcaches_p-1:0]                                dma_pkt_v_i,
    output logic [num_vcaches_p-1:0]                                dma_pkt_yumi_o,
    output logic [num_vcaches_p-1:0][vcache_dma_data_width_p-1:0]   dma_data_o,
    output logic [num_vcaches_p-1:0]                                dma_data_v_o,
    input  logic [num_vcaches_p-1:0]                                dma_data_ready_i,
    input  logic [num_vcaches_p-1:0][vcache_dma_data_width_p-1:0]   dma_data_i,
    input  logic [num_vcaches_p-1:0]                                dma_data_v_i,
    output logic [num_vcaches_p-1:0]                                dma_data_yumi_o,
    output logic [num_channels_p-1:0][pkt_width_lp-1:0]             ch_pkt_o,
    output logic [num_channels_p-1:0]                               ch_pkt_v_o,
    input  logic [num_channels_p-1:0]                               ch_pkt_yumi_i,
    output logic [num_channels_p-1:0][vcache_dma_data_width_p-1:0]  ch_wdata_o,
    output logic [num_channels_p-1:0]                               ch_wdata_v_o,
    input  logic [num_channels_p-1:0]                               ch_wdata_yumi_i,
    input  logic [num_channels_p-1:0][vcache_dma_data_width_p-1:0]  ch_rdata_i,
    input  logic [num_channels_p-1:0]                               ch_rdata_v_i,
    output logic [num_channels_p-1:0]                               ch_rdata_ready_o
`ifdef VCACHE_DMA_CHANNEL_MUX_PERF_EN
    ,
    output logic [num_channels_p-1:0][31:0]                         stall_count_o
`endif
);

    localparam int beats_lp = vcache_block_size_in_words_p * vcache_word_width_p
                              / vcache_dma_data_width_p;
    localparam int vpc_lp   = num_vcaches_p / num_channels_p;
    localparam int LW       = (vpc_lp > 1) ? $clog2(vpc_lp) : 1;
    localparam int BW       = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int PW       = (max_out_reads_p > 1) ? $clog2(max_out_reads_p) : 1;
    localparam int CW       = $clog2(max_out_reads_p + 1);
    localparam int WNR      = pkt_width_lp - 1;
    localparam int DW       = vcache_dma_data_width_p;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_ch
        logic [vpc_lp-1:0][pkt_width_lp-1:0] w_lpkt;
        logic [vpc_lp-1:0][DW-1:0]           w_ldata;
        logic [vpc_lp-1:0]                   w_lpv;
        logic [vpc_lp-1:0]                   w_ldv;
        logic [vpc_lp-1:0]                   w_lrdy;
        logic [vpc_lp-1:0]                   w_elig;

        logic [LW-1:0]  r_rr;
        logic [LW-1:0]  r_owner;
        logic           r_lock;
        logic [BW-1:0]  r_wcnt;
        logic [BW-1:0]  r_rcnt;
        logic [max_out_reads_p-1:0][LW-1:0] r_tags;
        logic [PW-1:0]  r_rd;
        logic [PW-1:0]  r_wr;
        logic [CW-1:0]  r_cnt;

        logic [2*vpc_lp-1:0] w_dbl;
        logic [vpc_lp-1:0]   w_rot;
        logic [LW-1:0]       w_off;
        logic [LW:0]         w_sum;
        logic [LW-1:0]       w_win;
        logic [LW-1:0]       w_win_nxt;
        logic                w_win_v;
        logic [LW-1:0]       w_head;
        logic                w_full;
        logic                w_empty;
        logic                w_accept;
        logic                w_accept_wr;
        logic                w_push;
        logic                w_pop;
        logic                w_rfire;
        logic                w_wfire;

        // Local lane l maps to global vcache V according to the mapping mode.
        for (genvar l = 0; l < vpc_lp; l++) begin : g_lane
            localparam int V = (map_mode_p == 0) ? (c * vpc_lp + l)
                                                 : (l * num_channels_p + c);
            assign w_lpkt[l]  = dma_pkt_i[V];
            assign w_lpv[l]   = dma_pkt_v_i[V];
            assign w_ldata[l] = dma_data_i[V];
            assign w_ldv[l]   = dma_data_v_i[V];
            assign w_lrdy[l]  = dma_data_ready_i[V];
            assign w_elig[l]  = reset_n_i & w_lpv[l] & ~r_lock
                                & (w_lpkt[l][WNR] | ~w_full);

            assign dma_pkt_yumi_o[V]  = w_win_v & (w_win == LW'(l)) & ch_pkt_yumi_i[c];
            assign dma_data_o[V]      = ch_rdata_i[c];
            assign dma_data_v_o[V]    = ~w_empty & (w_head == LW'(l)) & ch_rdata_v_i[c];
            assign dma_data_yumi_o[V] = r_lock & (r_owner == LW'(l)) & ch_wdata_yumi_i[c];
        end

        // Rotate so bit 0 is the rr pointer, pick the lowest set bit, rotate back.
        always_comb begin
            w_dbl   = {w_elig, w_elig} >> r_rr;
            w_rot   = w_dbl[vpc_lp-1:0];
            w_win_v = |w_rot;
            w_off   = '0;
            for (int i = vpc_lp - 1; i >= 0; i--) begin
                if (w_rot[i]) begin
                    w_off = LW'(i);
                end
            end
            w_sum = {1'b0, r_rr} + {1'b0, w_off};
            if (w_sum >= (LW + 1)'(vpc_lp)) begin
                w_sum = w_sum - (LW + 1)'(vpc_lp);
            end
            w_win = w_sum[LW-1:0];
        end

        assign w_win_nxt   = (w_win == LW'(vpc_lp - 1)) ? '0 : w_win + 1'b1;
        assign w_full      = (r_cnt == CW'(max_out_reads_p));
        assign w_empty     = (r_cnt == '0);
        assign w_head      = r_tags[r_rd];
        assign w_accept    = w_win_v & ch_pkt_yumi_i[c];
        assign w_accept_wr = w_accept & w_lpkt[w_win][WNR];
        assign w_push      = w_accept & ~w_lpkt[w_win][WNR];
        assign w_rfire     = ~w_empty & ch_rdata_v_i[c] & w_lrdy[w_head];
        assign w_pop       = w_rfire & (r_rcnt == BW'(beats_lp - 1));
        assign w_wfire     = r_lock & ch_wdata_yumi_i[c];

        assign ch_pkt_v_o[c]       = w_win_v;
        assign ch_pkt_o[c]         = w_lpkt[w_win];
        assign ch_wdata_o[c]       = w_ldata[r_owner];
        assign ch_wdata_v_o[c]     = r_lock & w_ldv[r_owner];
        assign ch_rdata_ready_o[c] = ~w_empty & w_lrdy[w_head];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_rr    <= '0;
                r_owner <= '0;
                r_lock  <= 1'b0;
                r_wcnt  <= '0;
                r_rcnt  <= '0;
                r_tags  <= '0;
                r_rd    <= '0;
                r_wr    <= '0;
                r_cnt   <= '0;
            end else begin
                if (w_accept) begin
                    r_rr <= w_win_nxt;
                end

                if (w_accept_wr) begin
                    r_lock  <= 1'b1;
                    r_owner <= w_win;
                    r_wcnt  <= '0;
                end else if (w_wfire) begin
                    if (r_wcnt == BW'(beats_lp - 1)) begin
                        r_lock <= 1'b0;
                        r_wcnt <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end

                if (w_push) begin
                    r_tags[r_wr] <= w_win;
                    r_wr <= (r_wr == PW'(max_out_reads_p - 1)) ? '0 : r_wr + 1'b1;
                end

                if (w_rfire) begin
                    r_rcnt <= w_pop ? '0 : r_rcnt + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= (r_rd == PW'(max_out_reads_p - 1)) ? '0 : r_rd + 1'b1;
                end

                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

`ifdef VCACHE_DMA_CHANNEL_MUX_PERF_EN
        logic [31:0] r_stall;
        logic        w_stall;

        // A valid request that is not eligible can only be held off by the lock or a full FIFO.
        assign w_stall = (w_win_v & ~ch_pkt_yumi_i[c]) | (|(w_lpv & ~w_elig));

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_stall <= '0;
            end else if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
                r_stall <= r_stall + 32'd1;
            end
        end

        assign stall_count_o[c] = r_stall;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_vcache_dma_channel_mux.sv
// ============================================================================
// Module   : tb_vcache_dma_channel_mux
// Brief    : Directed self-checking bench for vcache_dma_channel_mux, blocked
//            and interleaved mappings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vcache_dma_channel_mux;

    localparam int NV = 16;
    localparam int NC = 4;
    localparam int PW = 29;
    localparam int DW = 32;

    logic clk;
    logic rst_n;

    // Instance with blocked mapping
    logic [NV-1:0][PW-1:0] dma_pkt;
    logic [NV-1:0]         dma_pkt_v;
    logic [NV-1:0]         dma_pkt_yumi;
    logic [NV-1:0][DW-1:0] dma_data_out;
    logic [NV-1:0]         dma_data_vo;
    logic [NV-1:0]         dma_data_ready;
    logic [NV-1:0][DW-1:0] dma_data_in;
    logic [NV-1:0]         dma_data_vi;
    logic [NV-1:0]         dma_data_yumi;
    logic [NC-1:0][PW-1:0] ch_pkt;
    logic [NC-1:0]         ch_pkt_v;
    logic [NC-1:0]         ch_pkt_yumi;
    logic [NC-1:0][DW-1:0] ch_wdata;
    logic [NC-1:0]         ch_wdata_v;
    logic [NC-1:0]         ch_wdata_yumi;
    logic [NC-1:0][DW-1:0] ch_rdata;
    logic [NC-1:0]         ch_rdata_v;
    logic [NC-1:0]         ch_rdata_ready;

    // Instance with interleaved mapping
    logic [NV-1:0][PW-1:0] m_dma_pkt;
    logic [NV-1:0]         m_dma_pkt_v;
    logic [NV-1:0]         m_dma_pkt_yumi;
    logic [NV-1:0][DW-1:0] m_dma_data_out;
    logic [NV-1:0]         m_dma_data_vo;
    logic [NV-1:0]         m_dma_data_ready;
    logic [NV-1:0][DW-1:0] m_dma_data_in;
    logic [NV-1:0]         m_dma_data_vi;
    logic [NV-1:0]         m_dma_data_yumi;
    logic [NC-1:0][PW-1:0] m_ch_pkt;
    logic [NC-1:0]         m_ch_pkt_v;
    logic [NC-1:0]         m_ch_pkt_yumi;
    logic [NC-1:0][DW-1:0] m_ch_wdata;
    logic [NC-1:0]         m_ch_wdata_v;
    logic [NC-1:0]         m_ch_wdata_yumi;
    logic [NC-1:0][DW-1:0] m_ch_rdata;
    logic [NC-1:0]         m_ch_rdata_v;
    logic [NC-1:0]         m_ch_rdata_ready;

    int checks   = 0;
    int failures = 0;
    int nb;

    vcache_dma_channel_mux #(
        .num_vcaches_p(NV), .num_channels_p(NC), .map_mode_p(0),
        .vcache_addr_width_p(28), .vcache_block_size_in_words_p(8),
        .vcache_word_width_p(32), .vcache_dma_data_width_p(DW), .max_out_reads_p(4)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .dma_pkt_i(dma_pkt), .dma_pkt_v_i(dma_pkt_v), .dma_pkt_yumi_o(dma_pkt_yumi),
        .dma_data_o(dma_data_out), .dma_data_v_o(dma_data_vo), .dma_data_ready_i(dma_data_ready),
        .dma_data_i(dma_data_in), .dma_data_v_i(dma_data_vi), .dma_data_yumi_o(dma_data_yumi),
        .ch_pkt_o(ch_pkt), .ch_pkt_v_o(ch_pkt_v), .ch_pkt_yumi_i(ch_pkt_yumi),
        .ch_wdata_o(ch_wdata), .ch_wdata_v_o(ch_wdata_v), .ch_wdata_yumi_i(ch_wdata_yumi),
        .ch_rdata_i(ch_rdata), .ch_rdata_v_i(ch_rdata_v), .ch_rdata_ready_o(ch_rdata_ready)
    );

    vcache_dma_channel_mux #(
        .num_vcaches_p(NV), .num_channels_p(NC), .map_mode_p(1),
        .vcache_addr_width_p(28), .vcache_block_size_in_words_p(8),
        .vcache_word_width_p(32), .vcache_dma_data_width_p(DW), .max_out_reads_p(4)
    ) dut_il (
        .clk_i(clk), .reset_n_i(rst_n),
        .dma_pkt_i(m_dma_pkt), .dma_pkt_v_i(m_dma_pkt_v), .dma_pkt_yumi_o(m_dma_pkt_yumi),
        .dma_data_o(m_dma_data_out), .dma_data_v_o(m_dma_data_vo), .dma_data_ready_i(m_dma_data_ready),
        .dma_data_i(m_dma_data_in), .dma_data_v_i(m_dma_data_vi), .dma_data_yumi_o(m_dma_data_yumi),
        .ch_pkt_o(m_ch_pkt), .ch_pkt_v_o(m_ch_pkt_v), .ch_pkt_yumi_i(m_ch_pkt_yumi),
        .ch_wdata_o(m_ch_wdata), .ch_wdata_v_o(m_ch_wdata_v), .ch_wdata_yumi_i(m_ch_wdata_yumi),
        .ch_rdata_i(m_ch_rdata), .ch_rdata_v_i(m_ch_rdata_v), .ch_rdata_ready_o(m_ch_rdata_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mkpkt(input logic wnr, input int v);
        mkpkt = {wnr, 28'(32'h0100_0000 + v * 64)};
    endfunction

    function automatic logic [DW-1:0] rdpat(input int v, input int b);
        rdpat = 32'hA000_0000 + 32'(v * 256 + b);
    endfunction

    function automatic logic [DW-1:0] wrpat(input int v, input int b);
        wrpat = 32'h5000_0000 + 32'(v * 256 + b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        dma_pkt = '0; dma_pkt_v = '0; dma_data_ready = '1; dma_data_in = '0; dma_data_vi = '0;
        ch_pkt_yumi = '0; ch_wdata_yumi = '0; ch_rdata = '0; ch_rdata_v = '0;
        m_dma_pkt = '0; m_dma_pkt_v = '0; m_dma_data_ready = '1; m_dma_data_in = '0; m_dma_data_vi = '0;
        m_ch_pkt_yumi = '0; m_ch_wdata_yumi = '0; m_ch_rdata = '0; m_ch_rdata_v = '0;

        // Reset state, including a request held while in reset
        dma_pkt_v = 16'h0001;
        ch_pkt_yumi = 4'b0001;
        #1;
        chk("rst_ch_pkt_v", ch_pkt_v, 4'h0);
        chk("rst_pkt_yumi", dma_pkt_yumi, 16'h0);
        chk("rst_rdata_ready", ch_rdata_ready, 4'h0);
        chk("rst_fill_v", dma_data_vo, 16'h0);
        chk("rst_wdata_v", ch_wdata_v, 4'h0);
        chk("rst_evict_yumi", dma_data_yumi, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four reads on ch0 granted in round-robin order
        for (int k = 0; k < 4; k++) dma_pkt[k] = mkpkt(1'b0, k);
        dma_pkt_v = 16'h000F;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_pkt_yumi", dma_pkt_yumi, 16'(1 << k));
            chk("t1_ch_pkt", ch_pkt[0], mkpkt(1'b0, k));
            step();
            dma_pkt_v[k] = 1'b0;
        end
        ch_pkt_yumi = '0;

        // Fill blocks steered back in issue order
        ch_rdata_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 8; b++) begin
                ch_rdata[0] = rdpat(k, b);
                #1;
                chk("t1_fill_v", dma_data_vo, 16'(1 << k));
                chk("t1_fill_data", dma_data_out[k], rdpat(k, b));
                chk("t1_rdata_ready", ch_rdata_ready[0], 1'b1);
                step();
            end
        end
        ch_rdata_v[0] = 1'b0;
        #1;
        chk("t1_empty_ready", ch_rdata_ready[0], 1'b0);
        step();

        // Interleaved mapping: vcache 6 lands on ch2
        m_dma_pkt[6] = mkpkt(1'b0, 6);
        m_dma_pkt_v = 16'h0040;
        m_ch_pkt_yumi = 4'b0100;
        #1;
        chk("t4_ch_pkt_v", m_ch_pkt_v, 4'b0100);
        chk("t4_ch_pkt", m_ch_pkt[2], mkpkt(1'b0, 6));
        chk("t4_pkt_yumi", m_dma_pkt_yumi, 16'h0040);
        step();
        m_dma_pkt_v = '0;
        m_ch_pkt_yumi = '0;
        m_ch_rdata_v[2] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_ch_rdata[2] = rdpat(6, b);
            #1;
            chk("t4_fill_v", m_dma_data_vo, 16'h0040);
            chk("t4_fill_data", m_dma_data_out[6], rdpat(6, b));
            step();
        end
        m_ch_rdata_v[2] = 1'b0;
        #1;
        chk("t4_empty_ready", m_ch_rdata_ready[2], 1'b0);
        step();

        // Write lock on ch1: vcache 5 writes, vcache 4 read waits
        dma_pkt[5] = mkpkt(1'b1, 5);
        dma_pkt[4] = mkpkt(1'b0, 4);
        dma_pkt_v = 16'h0020;
        ch_pkt_yumi = 4'b0010;
        #1;
        chk("t2_wr_pkt_v", ch_pkt_v[1], 1'b1);
        chk("t2_wr_pkt", ch_pkt[1], mkpkt(1'b1, 5));
        chk("t2_wr_yumi", dma_pkt_yumi, 16'h0020);
        step();
        dma_pkt_v = 16'h0010;
        dma_data_vi = 16'h0030;
        ch_wdata_yumi = 4'b0010;
        for (int b = 0; b < 8; b++) begin
            dma_data_in[5] = wrpat(5, b);
            dma_data_in[4] = 32'hDEAD_0000 + 32'(b);
            #1;
            chk("t2_locked_pkt_v", ch_pkt_v[1], 1'b0);
            chk("t2_locked_pkt_yumi", dma_pkt_yumi, 16'h0);
            chk("t2_wdata_v", ch_wdata_v[1], 1'b1);
            chk("t2_wdata", ch_wdata[1], wrpat(5, b));
            chk("t2_evict_yumi", dma_data_yumi, 16'h0020);
            step();
        end
        #1;
        chk("t2_unlocked_wdata_v", ch_wdata_v[1], 1'b0);
        chk("t2_unlocked_evict_yumi", dma_data_yumi, 16'h0);
        chk("t2_rd_pkt_v", ch_pkt_v[1], 1'b1);
        chk("t2_rd_yumi", dma_pkt_yumi, 16'h0010);
        chk("t2_rd_pkt", ch_pkt[1], mkpkt(1'b0, 4));
        step();
        dma_pkt_v = '0;
        ch_pkt_yumi = '0;
        dma_data_vi = '0;
        ch_wdata_yumi = '0;

        // Tag FIFO full on ch2: fifth read waits for the first block
        for (int v = 8; v < 12; v++) dma_pkt[v] = mkpkt(1'b0, v);
        dma_pkt_v = 16'h0F00;
        ch_pkt_yumi = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_fill_fifo_yumi", dma_pkt_yumi, 16'(1 << (8 + k)));
            step();
            dma_pkt_v[8 + k] = 1'b0;
        end
        dma_pkt[8] = mkpkt(1'b0, 20);
        dma_pkt_v[8] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_full_pkt_v", ch_pkt_v[2], 1'b0);
            chk("t3_full_yumi", dma_pkt_yumi, 16'h0);
            step();
        end
        ch_rdata_v[2] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ch_rdata[2] = rdpat(8, b);
            #1;
            chk("t3_fill_v", dma_data_vo, 16'h0100);
            chk("t3_fill_data", dma_data_out[8], rdpat(8, b));
            chk("t3_still_full", ch_pkt_v[2], 1'b0);
            step();
        end
        ch_rdata_v[2] = 1'b0;
        #1;
        chk("t3_regrant_v", ch_pkt_v[2], 1'b1);
        chk("t3_regrant_yumi", dma_pkt_yumi, 16'h0100);
        chk("t3_regrant_pkt", ch_pkt[2], mkpkt(1'b0, 20));
        step();
        dma_pkt_v = '0;
        ch_pkt_yumi = '0;

        // Fill with toggling ready on ch3
        dma_pkt[13] = mkpkt(1'b0, 13);
        dma_pkt_v = 16'h2000;
        ch_pkt_yumi = 4'b1000;
        #1;
        chk("t5_grant", dma_pkt_yumi, 16'h2000);
        step();
        dma_pkt_v = '0;
        ch_pkt_yumi = '0;
        ch_rdata_v[3] = 1'b1;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            dma_data_ready[13] = (i % 2) == 1;
            ch_rdata[3] = rdpat(13, nb);
            #1;
            chk("t5_ready_follow", ch_rdata_ready[3], 1'((i % 2) == 1));
            chk("t5_fill_v", dma_data_vo[13], 1'b1);
            if ((i % 2) == 1) chk("t5_fill_data", dma_data_out[13], rdpat(13, nb));
            step();
            if ((i % 2) == 1) nb++;
        end
        dma_data_ready[13] = 1'b1;
        #1;
        chk("t5_popped_v", dma_data_vo[13], 1'b0);
        chk("t5_popped_ready", ch_rdata_ready[3], 1'b0);
        ch_rdata_v[3] = 1'b0;
        step();

        // Reset asserted at beat 3 of a ch1 write
        dma_pkt[6] = mkpkt(1'b1, 6);
        dma_pkt[7] = mkpkt(1'b0, 7);
        dma_pkt_v = 16'h0040;
        ch_pkt_yumi = 4'b0010;
        #1;
        chk("t6_wr_pkt", ch_pkt[1], mkpkt(1'b1, 6));
        chk("t6_wr_yumi", dma_pkt_yumi, 16'h0040);
        step();
        dma_pkt_v = 16'h0080;
        dma_data_vi[6] = 1'b1;
        ch_wdata_yumi = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            dma_data_in[6] = wrpat(6, b);
            #1;
            chk("t6_wdata", ch_wdata[1], wrpat(6, b));
            step();
        end
        dma_data_in[6] = wrpat(6, 3);
        ch_rdata_v[1] = 1'b1;
        #1;
        chk("t6_pre_wdata_v", ch_wdata_v[1], 1'b1);
        chk("t6_pre_fill_v", dma_data_vo, 16'h0010);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wdata_v", ch_wdata_v, 4'h0);
        chk("t6_rst_evict_yumi", dma_data_yumi, 16'h0);
        chk("t6_rst_pkt_v", ch_pkt_v, 4'h0);
        chk("t6_rst_pkt_yumi", dma_pkt_yumi, 16'h0);
        chk("t6_rst_fill_v", dma_data_vo, 16'h0);
        chk("t6_rst_ready", ch_rdata_ready, 4'h0);
        step();
        rst_n = 1'b1;
        ch_rdata_v[1] = 1'b0;
        #1;
        chk("t6_post_wdata_v", ch_wdata_v[1], 1'b0);
        chk("t6_post_evict_yumi", dma_data_yumi, 16'h0);
        chk("t6_post_pkt_v", ch_pkt_v[1], 1'b1);
        chk("t6_post_yumi", dma_pkt_yumi, 16'h0080);
        chk("t6_post_pkt", ch_pkt[1], mkpkt(1'b0, 7));
        step();
        dma_pkt_v = '0;
        ch_pkt_yumi = '0;
        dma_data_vi = '0;
        ch_wdata_yumi = '0;
        #1;
        chk("t6_read_tracked", ch_rdata_ready[1], 1'b1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vcache_dma_channel_mux.md
Name: vcache_dma_channel_mux

Overview:
- Funnels the DMA interfaces of num_vcaches_p vcaches onto num_channels_p DRAM channels.
- Per channel: round-robin arbitration of DMA packets, a write-data lock, and an in-order tag FIFO that steers returning read data back to the requesting vcache.
- Sits between the flattened vcache DMA bundle and the DRAM controller/testbench memory.
- Adds real arbitration and outstanding-read tracking to what was previously pure wiring.

Parameters:
- num_vcaches_p, 16, total vcache DMA ports; must be a multiple of num_channels_p.
- num_channels_p, 4, DRAM channels.
- map_mode_p, 0, vcache-to-channel mapping: 0 = blocked (ch = v / (num_vcaches_p/num_channels_p)); 1 = interleaved (ch = v % num_channels_p).
- vcache_addr_width_p, 28, DMA address width.
- vcache_block_size_in_words_p, 8, words per cache block.
- vcache_word_width_p, 32, bits per word.
- vcache_dma_data_width_p, 32, DMA data beat width; must divide block size times word width.
- max_out_reads_p, 4, outstanding reads per channel (tag FIFO depth), ≥1.
- Derived: beats_lp = block_words*word_width/dma_data_width; vpc_lp = num_vcaches_p/num_channels_p; pkt_width_lp = bsg_cache_dma_pkt width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- dma_pkt_i  in  [num_vcaches_p][pkt_width_lp]  vcache DMA packet; MSB = write_not_read
- dma_pkt_v_i  in  [num_vcaches_p]  packet valid
- dma_pkt_yumi_o  out  [num_vcaches_p]  packet consumed
- dma_data_o  out  [num_vcaches_p][dma_data_width]  read fill data to vcache
- dma_data_v_o  out  [num_vcaches_p]  fill valid
- dma_data_ready_i  in  [num_vcaches_p]  vcache ready for fill
- dma_data_i  in  [num_vcaches_p][dma_data_width]  evict (write) data from vcache
- dma_data_v_i  in  [num_vcaches_p]  evict valid
- dma_data_yumi_o  out  [num_vcaches_p]  evict beat consumed
- ch_pkt_o  out  [num_channels_p][pkt_width_lp]  granted packet
- ch_pkt_v_o  out  [num_channels_p]  packet valid
- ch_pkt_yumi_i  in  [num_channels_p]  DRAM accepted packet
- ch_wdata_o  out  [num_channels_p][dma_data_width]  write beat
- ch_wdata_v_o  out  [num_channels_p]  write beat valid
- ch_wdata_yumi_i  in  [num_channels_p]  write beat consumed
- ch_rdata_i  in  [num_channels_p][dma_data_width]  read beat from DRAM
- ch_rdata_v_i  in  [num_channels_p]  read beat valid
- ch_rdata_ready_o  out  [num_channels_p]  mux ready for read beat

Behaviour:
- Reset (reset_n_i low, async): all v/yumi/ready outputs 0; rr pointers 0; tag FIFOs empty; write locks clear; beat counters 0. Reset mid-transfer abandons in-flight beats; no recovery.
- Channels are fully independent. Each channel's candidate set is the vpc_lp vcaches mapped to it by map_mode_p; local index 0..vpc_lp-1 in ascending vcache order.
- Packet arbitration, per channel, combinational over registered state:
  - A request is eligible iff dma_pkt_v_i is set, no write lock is held, and, if it is a read, the tag FIFO is not full.
  - Winner = first eligible at or after rr_ptr, wrapping.
  - ch_pkt_v_o = any eligible; ch_pkt_o = winner's packet; dma_pkt_yumi_o[winner] = ch_pkt_yumi_i.
  - On yumi: rr_ptr <= winner+1 mod vpc_lp. Without yumi the pointer holds and the grant may change next cycle; downstream must not assume stable packets.
- Write lock:
  - Accepted write: lock owner = winner, beat counter = 0.
  - While locked: ch_wdata_o/v_o = owner's dma_data_i/v_i; dma_data_yumi_o[owner] = ch_wdata_yumi_i; counter increments per yumi.
  - At beats_lp-1 the yumi clears the lock.
  - No packet is granted while locked, including the cycle the last beat is consumed. The next grant is possible the following cycle.
  - Evict data presented outside a lock is never consumed.
- Read return:
  - Accepted read pushes the winner's local index into the tag FIFO.
  - FIFO non-empty: head selects the target vcache. dma_data_o/v_o[head] = ch_rdata_i/v_i; ch_rdata_ready_o = dma_data_ready_i[head].
  - FIFO empty: ch_rdata_ready_o = 0 and all fill v outputs are 0.
  - Read beat counter increments on v&ready; at beats_lp-1 the FIFO pops and the counter resets.
  - Push and pop in the same cycle are legal when full: the pop frees space, but eligibility uses pre-pop full, so there is no push that cycle.
  - Reads and a write lock proceed concurrently.
- Ordering: DRAM returns reads in per-channel issue order.

Optional Feature:
- VCACHE_DMA_CHANNEL_MUX_PERF_EN: adds output stall_count_o [num_channels_p][32].
  - Increments each cycle ch_pkt_v_o is high without ch_pkt_yumi_i, or some dma_pkt_v_i is blocked solely by a full tag FIFO or a write lock.
  - Saturates at 2^32-1; cleared by reset.
- Without the macro: the port and counters are absent.

Test Plan:
- num_vcaches_p=16, num_channels_p=4, map_mode_p=0; vcaches 0-3 each request a read together, ch0 yumi always 1 → grants 0,1,2,3 on consecutive cycles, each beats_lp=8 fill routed back to the issuing vcache in order.
- vcache 5 write, then vcache 4 read pending → vcache 4 granted only the cycle after the 8th wdata yumi; the 8 beats match vcache 5 data exactly.
- 5 reads on ch2 with max_out_reads_p=4, no rdata → 4 accepted, 5th blocked until first full block returns, then granted next cycle.
- map_mode_p=1, vcache 6 read → appears on ch2, fill returns to vcache 6.
- Fill with dma_data_ready_i toggling 1/0 → ch_rdata_ready_o follows it; counter advances only on v&ready; pop after exactly 8 handshakes.
- Assert reset_n_i mid-write (beat 3) → all valid outputs 0 same cycle; after release, lock clear and a new read granted.
